// File: rtl/mmu_ptw_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmu_ptw_ctrl : page-table-walk controller, one PTE-group burst per TLB miss |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module mmu_ptw_ctrl #(
    parameter int ADDR_WIDTH  = 35,
    parameter int VPN_WIDTH   = 23,
    parameter int TLB_ENTRIES = 32,
    parameter int PTE_LOG2    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_lookup,
    input  logic                  i_hit,
    input  logic [ADDR_WIDTH-1:0] i_virtualAddr,
    input  logic [ADDR_WIDTH-1:0] i_ptBase,
    output logic                  o_ptwUpdate,
    output logic [63:0]           o_ptwPTE,
    output logic [4:0]            o_indexVictim,
    output logic                  o_arvalid,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    output logic [7:0]            o_arlen,
    input  logic                  i_arready,
    input  logic                  i_rvalid,
    input  logic [63:0]           i_rdata,
    input  logic                  i_rerr,
    output logic                  o_rready,
    output logic                  o_busy,
    output logic                  o_walkErr
);

    localparam int                   c_beatW      = (PTE_LOG2 > 0) ? PTE_LOG2 : 1;
    localparam int                   c_group      = 1 << PTE_LOG2;
    localparam logic [c_beatW-1:0]   c_lastBeat   = c_beatW'(c_group - 1);
    localparam logic [4:0]           c_victimLast = 5'(TLB_ENTRIES - 1);
    localparam logic [VPN_WIDTH-1:0] c_avpnMask   = ~VPN_WIDTH'(c_group - 1);

    localparam logic [2:0] c_stIdle    = 3'd0;
    localparam logic [2:0] c_stReq     = 3'd1;
    localparam logic [2:0] c_stWait    = 3'd2;
    localparam logic [2:0] c_stPresent = 3'd3;
    localparam logic [2:0] c_stDone    = 3'd4;
    localparam logic [2:0] c_stDrain   = 3'd5;
    localparam logic [2:0] c_stErr     = 3'd6;

    logic [2:0]            r_state;
    logic [2:0]            w_nextState;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [63:0]           r_pte;
    logic [1:0]            r_hold;
    logic [c_beatW-1:0]    r_beat;
    logic [4:0]            r_victim;

    logic                  w_miss;
    logic                  w_lastBeat;
    logic [VPN_WIDTH-1:0]  w_avpn;
    logic [ADDR_WIDTH-1:0] w_reqAddr;
    logic [1:0]            w_holdLoad;
    logic                  w_unusedVaBits;

    assign w_miss         = i_lookup & ~i_hit;
    assign w_lastBeat     = (r_beat == c_lastBeat);
    assign w_avpn         = i_virtualAddr[ADDR_WIDTH-1 -: VPN_WIDTH] & c_avpnMask;
    assign w_reqAddr      = i_ptBase + (ADDR_WIDTH'(w_avpn) << 3);
    assign w_unusedVaBits = ^i_virtualAddr[ADDR_WIDTH-VPN_WIDTH-1:0];
    // Hold minus one: cRCPT spans 3 update cycles, RCPT 2, first beat adds the APTE cycle.
    assign w_holdLoad     = (i_rdata[63] ? 2'd2 : 2'd1) + ((r_beat == '0) ? 2'd1 : 2'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_stIdle;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_stIdle:    if (w_miss) w_nextState = c_stReq;
            c_stReq:     if (i_arready) w_nextState = c_stWait;
            c_stWait: begin
                if (i_rvalid) begin
                    if (i_rerr) begin
                        w_nextState = w_lastBeat ? c_stErr : c_stDrain;
                    end else begin
                        w_nextState = c_stPresent;
                    end
                end
            end
            c_stPresent: if (r_hold == 2'd0) w_nextState = w_lastBeat ? c_stDone : c_stWait;
            c_stDone:    w_nextState = c_stIdle;
            c_stDrain:   if (i_rvalid && w_lastBeat) w_nextState = c_stErr;
            c_stErr:     w_nextState = c_stIdle;
            default:     w_nextState = c_stIdle;
        endcase
    end

    always_comb begin
        o_arvalid   = 1'b0;
        o_rready    = 1'b0;
        o_ptwUpdate = 1'b0;
        o_walkErr   = 1'b0;
        o_busy      = (r_state != c_stIdle);
        case (r_state)
            c_stReq:     o_arvalid   = 1'b1;
            c_stWait:    o_rready    = 1'b1;
            c_stPresent: o_ptwUpdate = 1'b1;
            c_stDrain:   o_rready    = 1'b1;
            c_stErr:     o_walkErr   = 1'b1;
            default:     ;
        endcase
    end

    // Beats of an errored burst are still counted so the drain knows when the burst ends.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_araddr <= '0;
            r_pte    <= '0;
            r_hold   <= '0;
            r_beat   <= '0;
            r_victim <= '0;
        end else begin
            case (r_state)
                c_stIdle: begin
                    if (w_miss) begin
                        r_araddr <= w_reqAddr;
                        r_beat   <= '0;
                    end
                end
                c_stWait: begin
                    if (i_rvalid) begin
                        if (i_rerr) begin
                            if (!w_lastBeat) r_beat <= r_beat + c_beatW'(1);
                        end else begin
                            r_pte  <= i_rdata;
                            r_hold <= w_holdLoad;
                        end
                    end
                end
                c_stPresent: begin
                    if (r_hold != 2'd0) begin
                        r_hold <= r_hold - 2'd1;
                    end else if (!w_lastBeat) begin
                        r_beat <= r_beat + c_beatW'(1);
                    end
                end
                c_stDrain: begin
                    if (i_rvalid && !w_lastBeat) r_beat <= r_beat + c_beatW'(1);
                end
                c_stDone: begin
                    r_victim <= (r_victim == c_victimLast) ? 5'd0 : r_victim + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_araddr      = r_araddr;
    assign o_ptwPTE      = r_pte;
    assign o_indexVictim = r_victim;
    assign o_arlen       = 8'(c_group - 1);

endmodule
`default_nettype wire

// File: tb/tb_mmu_ptw_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mmu_ptw_ctrl : scoreboard bench for the page-table-walk controller      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mmu_ptw_ctrl;
    localparam int ADDR_WIDTH  = 35;
    localparam int VPN_WIDTH   = 23;
    localparam int TLB_ENTRIES = 32;
    localparam int PTE_LOG2    = 1;
    localparam int G           = 1 << PTE_LOG2;

    logic                  i_clk = 1'b0;
    logic                  i_rst_n = 1'b0;
    logic                  i_lookup = 1'b0;
    logic                  i_hit = 1'b0;
    logic [ADDR_WIDTH-1:0] i_virtualAddr = '0;
    logic [ADDR_WIDTH-1:0] i_ptBase = '0;
    logic                  o_ptwUpdate;
    logic [63:0]           o_ptwPTE;
    logic [4:0]            o_indexVictim;
    logic                  o_arvalid;
    logic [ADDR_WIDTH-1:0] o_araddr;
    logic [7:0]            o_arlen;
    logic                  i_arready = 1'b0;
    logic                  i_rvalid = 1'b0;
    logic [63:0]           i_rdata = '0;
    logic                  i_rerr = 1'b0;
    logic                  o_rready;
    logic                  o_busy;
    logic                  o_walkErr;

    always #5 i_clk = ~i_clk;

    mmu_ptw_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .VPN_WIDTH  (VPN_WIDTH),
        .TLB_ENTRIES(TLB_ENTRIES),
        .PTE_LOG2   (PTE_LOG2)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lookup(i_lookup), .i_hit(i_hit),
        .i_virtualAddr(i_virtualAddr), .i_ptBase(i_ptBase),
        .o_ptwUpdate(o_ptwUpdate), .o_ptwPTE(o_ptwPTE), .o_indexVictim(o_indexVictim),
        .o_arvalid(o_arvalid), .o_araddr(o_araddr), .o_arlen(o_arlen), .i_arready(i_arready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rerr(i_rerr), .o_rready(o_rready),
        .o_busy(o_busy), .o_walkErr(o_walkErr)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected update words are queued per cycle, observed ones are collected per cycle.
    logic [63:0]           expUpdQ[$];
    logic [63:0]           updQ[$];
    logic [ADDR_WIDTH-1:0] arAddrQ[$];
    logic [4:0]            vicQ[$];
    int                    errCnt;
    int                    errCyc;
    int                    lastBeatCyc;
    logic [7:0]            arlenSeen;
    logic                  busyAfterMiss;
    bit                    timedOut;
    logic [4:0]            expVictim = 5'd0;

    function automatic logic [ADDR_WIDTH-1:0] model_addr(input logic [ADDR_WIDTH-1:0] va,
                                                         input logic [ADDR_WIDTH-1:0] base);
        logic [VPN_WIDTH-1:0]  vpn;
        logic [ADDR_WIDTH-1:0] off;
        vpn = va >> (ADDR_WIDTH - VPN_WIDTH);
        vpn = (vpn >> PTE_LOG2) << PTE_LOG2;
        off = '0;
        off[VPN_WIDTH+2:0] = {vpn, 3'b000};
        return base + off;
    endfunction

    task automatic push_expected(input logic [63:0] p0, input logic [63:0] p1);
        logic [63:0] ptes[G];
        int          h;
        ptes[0] = p0;
        ptes[1] = p1;
        expUpdQ.delete();
        for (int b = 0; b < G; b++) begin
            h = (ptes[b][63] ? 3 : 2) + ((b == 0) ? 1 : 0);
            for (int k = 0; k < h; k++) expUpdQ.push_back(ptes[b]);
        end
    endtask

    // Fabric model and observer for one walk; stops when the DUT returns to IDLE.
    task automatic run_walk(input logic [ADDR_WIDTH-1:0] va, input logic [63:0] p0, input logic [63:0] p1,
                            input bit e0, input bit e1, input int arDelay,
                            input bit junk, input bit extraMiss, input bit abortOnUpd);
        logic [63:0] ptes[G];
        bit          errs[G];
        int          beat;
        int          arWait;
        int          cyc;
        bit          done;
        ptes[0] = p0; ptes[1] = p1; errs[0] = e0; errs[1] = e1;
        beat = 0; arWait = arDelay; cyc = 0; done = 0;
        updQ.delete(); arAddrQ.delete(); vicQ.delete();
        errCnt = 0; errCyc = -1; lastBeatCyc = -1; timedOut = 0; busyAfterMiss = 1'b0;
        @(negedge i_clk);
        i_lookup = 1'b1; i_hit = 1'b0; i_virtualAddr = va;
        while (!done) begin
            @(negedge i_clk);
            cyc++;
            i_lookup      = extraMiss && (cyc == 3);
            i_virtualAddr = (extraMiss && cyc == 3) ? ~va : va;
            if (cyc == 1) busyAfterMiss = o_busy;
            if (o_arvalid) begin
                arAddrQ.push_back(o_araddr);
                arlenSeen = o_arlen;
            end
            if (o_ptwUpdate) updQ.push_back(o_ptwPTE);
            if (o_busy) vicQ.push_back(o_indexVictim);
            if (o_walkErr) begin
                errCnt++;
                errCyc = cyc;
            end
            if (abortOnUpd && o_ptwUpdate) done = 1;
            else if (!o_busy) done = 1;
            else if (cyc >= 200) begin
                timedOut = 1;
                done = 1;
            end
            if (!done) begin
                i_arready = o_arvalid && (arWait == 0);
                if (o_arvalid && arWait > 0) arWait--;
                if (o_rready && beat < G) begin
                    i_rvalid = 1'b1; i_rdata = ptes[beat]; i_rerr = errs[beat];
                    lastBeatCyc = cyc;
                    beat++;
                end else if (junk) begin
                    i_rvalid = 1'b1; i_rdata = 64'hDEAD_BEEF_DEAD_BEEF; i_rerr = 1'b1;
                end else begin
                    i_rvalid = 1'b0; i_rerr = 1'b0;
                end
            end
        end
        i_arready = 1'b0; i_rvalid = 1'b0; i_rerr = 1'b0; i_lookup = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_arvalid, o_rready, o_ptwUpdate, o_busy, o_walkErr} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl actual=%b required=00000",
                     {o_arvalid, o_rready, o_ptwUpdate, o_busy, o_walkErr});
        end
        checks++;
        if (o_indexVictim !== 5'd0) begin
            errors++;
            $display("FAIL reset_victim actual=%0d required=0", o_indexVictim);
        end
        checks++;
        if (o_araddr !== '0 || o_ptwPTE !== 64'd0) begin
            errors++;
            $display("FAIL reset_data actual=%h/%h required=0/0", o_araddr, o_ptwPTE);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_addr_backpressure();
        i_ptBase = 35'h1000;
        push_expected(64'h0000_1111_2222_3330, 64'h0000_4444_5555_6660);
        run_walk(35'h0_0020_1000, 64'h0000_1111_2222_3330, 64'h0000_4444_5555_6660,
                 0, 0, 3, 0, 0, 0);
        checks++;
        if (timedOut || !busyAfterMiss) begin
            errors++;
            $display("FAIL bp_progress actual=timeout%0d busy%0b required=timeout0 busy1", timedOut, busyAfterMiss);
        end
        checks++;
        if (arAddrQ.size() !== 4) begin
            errors++;
            $display("FAIL bp_arvalid_cycles actual=%0d required=4", arAddrQ.size());
        end
        foreach (arAddrQ[i]) begin
            checks++;
            if (arAddrQ[i] !== 35'h2000) begin
                errors++;
                $display("FAIL bp_araddr[%0d] actual=%h required=2000", i, arAddrQ[i]);
            end
        end
        checks++;
        if (arlenSeen !== 8'd1) begin
            errors++;
            $display("FAIL bp_arlen actual=%0d required=1", arlenSeen);
        end
        checks++;
        if (updQ.size() !== expUpdQ.size()) begin
            errors++;
            $display("FAIL bp_upd_len actual=%0d required=%0d", updQ.size(), expUpdQ.size());
        end
        expVictim = 5'd1;
        checks++;
        if (o_indexVictim !== expVictim) begin
            errors++;
            $display("FAIL bp_victim_after actual=%0d required=%0d", o_indexVictim, expVictim);
        end
    endtask

    task automatic test_rcpt();
        logic [ADDR_WIDTH-1:0] va;
        va = 35'h5_1234_5000;
        i_ptBase = 35'h7_FFFF_F800;
        push_expected(64'h0123_4567_89AB_CDE0, 64'h0FED_CBA9_8765_4320);
        run_walk(va, 64'h0123_4567_89AB_CDE0, 64'h0FED_CBA9_8765_4320, 0, 0, 0, 1, 0, 0);
        checks++;
        if (arAddrQ.size() !== 1 || arAddrQ[0] !== model_addr(va, i_ptBase)) begin
            errors++;
            $display("FAIL rcpt_araddr actual=%h (n=%0d) required=%h", arAddrQ[0], arAddrQ.size(),
                     model_addr(va, i_ptBase));
        end
        checks++;
        if (updQ.size() !== expUpdQ.size()) begin
            errors++;
            $display("FAIL rcpt_upd_len actual=%0d required=%0d", updQ.size(), expUpdQ.size());
        end else begin
            foreach (updQ[i]) begin
                checks++;
                if (updQ[i] !== expUpdQ[i]) begin
                    errors++;
                    $display("FAIL rcpt_upd[%0d] actual=%h required=%h", i, updQ[i], expUpdQ[i]);
                end
            end
        end
        foreach (vicQ[i]) begin
            checks++;
            if (vicQ[i] !== expVictim) begin
                errors++;
                $display("FAIL rcpt_victim_stable[%0d] actual=%0d required=%0d", i, vicQ[i], expVictim);
            end
        end
        expVictim = expVictim + 5'd1;
        checks++;
        if (o_indexVictim !== expVictim) begin
            errors++;
            $display("FAIL rcpt_victim_after actual=%0d required=%0d", o_indexVictim, expVictim);
        end
    endtask

    task automatic test_crcpt();
        i_ptBase = 35'h0_0800_0000;
        push_expected(64'h8000_0000_AAAA_0001, 64'h8123_0000_BBBB_0002);
        run_walk(35'h2_0000_7000, 64'h8000_0000_AAAA_0001, 64'h8123_0000_BBBB_0002, 0, 0, 1, 0, 1, 0);
        checks++;
        if (updQ.size() !== expUpdQ.size()) begin
            errors++;
            $display("FAIL crcpt_upd_len actual=%0d required=%0d", updQ.size(), expUpdQ.size());
        end else begin
            foreach (updQ[i]) begin
                checks++;
                if (updQ[i] !== expUpdQ[i]) begin
                    errors++;
                    $display("FAIL crcpt_upd[%0d] actual=%h required=%h", i, updQ[i], expUpdQ[i]);
                end
            end
        end
        checks++;
        if (arAddrQ.size() !== 2) begin
            errors++;
            $display("FAIL crcpt_single_request actual=%0d required=2", arAddrQ.size());
        end
        repeat (2) begin
            @(negedge i_clk);
            checks++;
            if (o_busy !== 1'b0 || o_arvalid !== 1'b0) begin
                errors++;
                $display("FAIL crcpt_second_miss_ignored actual=busy%0b arvalid%0b required=0 0", o_busy, o_arvalid);
            end
        end
        expVictim = expVictim + 5'd1;
        checks++;
        if (o_indexVictim !== expVictim) begin
            errors++;
            $display("FAIL crcpt_victim_after actual=%0d required=%0d", o_indexVictim, expVictim);
        end
    endtask

    task automatic test_error();
        run_walk(35'h1_2345_6000, 64'h0000_0000_0000_0EE0, 64'h0000_0000_0000_0EE1, 1, 0, 0, 0, 0, 0);
        checks++;
        if (updQ.size() !== 0) begin
            errors++;
            $display("FAIL err_no_update actual=%0d required=0", updQ.size());
        end
        checks++;
        if (errCnt !== 1) begin
            errors++;
            $display("FAIL err_pulse_count actual=%0d required=1", errCnt);
        end
        checks++;
        if (errCyc !== lastBeatCyc + 1) begin
            errors++;
            $display("FAIL err_pulse_after_drain actual=%0d required=%0d", errCyc, lastBeatCyc + 1);
        end
        checks++;
        if (o_indexVictim !== expVictim || timedOut) begin
            errors++;
            $display("FAIL err_victim_unchanged actual=%0d required=%0d", o_indexVictim, expVictim);
        end
    endtask

    task automatic test_reset_mid_walk();
        run_walk(35'h0_0040_3000, 64'h0000_0000_1234_5670, 64'h0000_0000_7654_3210, 0, 0, 0, 0, 0, 1);
        checks++;
        if (o_ptwUpdate !== 1'b1 || o_indexVictim !== expVictim) begin
            errors++;
            $display("FAIL rst_precondition actual=upd%0b vic%0d required=upd1 vic%0d",
                     o_ptwUpdate, o_indexVictim, expVictim);
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_ptwUpdate !== 1'b0 || o_busy !== 1'b0 || o_indexVictim !== 5'd0) begin
            errors++;
            $display("FAIL rst_async actual=upd%0b busy%0b vic%0d required=0 0 0",
                     o_ptwUpdate, o_busy, o_indexVictim);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        expVictim = 5'd0;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_rready !== 1'b0) begin
            errors++;
            $display("FAIL rst_burst_forgotten actual=busy%0b rready%0b required=0 0", o_busy, o_rready);
        end
    endtask

    task automatic test_victim_wrap();
        logic [63:0] p0;
        logic [63:0] p1;
        for (int w = 0; w <= TLB_ENTRIES; w++) begin
            p0 = {$urandom, $urandom};
            p1 = {$urandom, $urandom};
            run_walk(ADDR_WIDTH'({$urandom, $urandom}), p0, p1, 0, 0, w % 2, 0, 0, 0);
            checks++;
            if (vicQ.size() == 0 || vicQ[0] !== expVictim || timedOut) begin
                errors++;
                $display("FAIL wrap_victim[%0d] actual=%0d required=%0d", w,
                         (vicQ.size() == 0) ? 0 : int'(vicQ[0]), expVictim);
            end
            expVictim = (expVictim == 5'(TLB_ENTRIES - 1)) ? 5'd0 : expVictim + 5'd1;
        end
    endtask

    initial begin
        test_reset();
        test_addr_backpressure();
        test_rcpt();
        test_crcpt();
        test_error();
        test_reset_mid_walk();
        test_victim_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
